// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, lane geometry,
// the default halt sentinel and the RV32I major opcodes used to classify instructions.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_RUN,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam logic [6:0]  HALT_OPC_DEFAULT = 7'b1111111;
    localparam int unsigned LANE_W           = 8;
    localparam int unsigned LANES            = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: lane counter, zero-padded short final word,
// and a one-cycle write strobe with the completed word registered alongside it.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic        i_last,
    input  logic [7:0]  i_data,
    output logic        o_we,
    output logic [31:0] o_wdata
);

    logic [1:0]  r_lane;
    logic [31:0] r_word;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] w_word;
    logic        w_complete;

    // Lanes above r_lane are held at zero, so a word closed early by i_last is already padded.
    always_comb begin
        w_word     = r_word | ({24'h0, i_data} << (LANE_W * r_lane));
        w_complete = (r_lane == 2'(LANES - 1)) || i_last;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane  <= '0;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (i_accept) begin
                if (w_complete) begin
                    r_wdata <= w_word;
                    r_we    <= 1'b1;
                    r_word  <= '0;
                    r_lane  <= '0;
                end else begin
                    r_word <= w_word;
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

    assign o_we    = r_we;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/imem_loader.sv
// RV32i program loader: streams host bytes into instruction memory, then releases and halts the core.
// Build macro IMEM_LOADER_CHECKSUM_EN adds chk_expected/chk_sum and a checksum gate on release.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [6:0]  HALT_OPCODE = HALT_OPC_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       instr_if_id,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  logic [31:0]       chk_expected,
    output logic [31:0]       chk_sum,
`endif
    output logic              core_rst,
    output logic              core_enable,
    output logic [ADDR_W:0]   word_count,
    output logic              halted,
    output logic              load_err
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t          r_state;
    logic            r_byte_ready;
    logic            r_core_rst;
    logic            r_core_enable;
    logic            r_halted;
    logic            r_load_err;
    logic [ADDR_W:0] r_word_count;

    logic            w_accept;
    logic            w_overflow;
    logic            w_pack_accept;
    logic            w_start_ok;
    logic            w_we;
    logic [31:0]     w_wdata;
    logic [ADDR_W:0] w_words_done;
    logic            w_flush_ok;
    logic            w_unused_instr;

    // A completed word still in its write cycle counts as written for the capacity check.
    always_comb begin
        w_accept      = byte_valid & r_byte_ready;
        w_words_done  = r_word_count + (ADDR_W + 1)'(w_we);
        w_overflow    = w_accept & (w_words_done == MAX_WORDS);
        w_pack_accept = w_accept & ~w_overflow;
        w_start_ok    = start & ((r_state == ST_IDLE) || (r_state == ST_HALT) || (r_state == ST_ERR));
    end

    assign w_unused_instr = ^instr_if_id[31:7];

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_ok),
        .i_accept (w_pack_accept),
        .i_last   (byte_last),
        .i_data   (byte_data),
        .o_we     (w_we),
        .o_wdata  (w_wdata)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_chk_sum;
    logic [31:0] w_chk_final;

    // FLUSH coincides with the final word's write, so fold it in before comparing.
    always_comb begin
        w_chk_final = r_chk_sum + (w_we ? w_wdata : '0);
        w_flush_ok  = (w_chk_final == chk_expected);
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_chk_sum <= '0;
        end else if (w_we) begin
            r_chk_sum <= r_chk_sum + w_wdata;
        end
    end

    assign chk_sum = r_chk_sum;
`else
    assign w_flush_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_word_count <= '0;
        end else if (w_we) begin
            r_word_count <= r_word_count + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_byte_ready  <= 1'b0;
            r_core_rst    <= 1'b1;
            r_core_enable <= 1'b0;
            r_halted      <= 1'b0;
            r_load_err    <= 1'b0;
        end else if (w_start_ok) begin
            r_state       <= ST_LOAD;
            r_byte_ready  <= 1'b1;
            r_core_rst    <= 1'b1;
            r_core_enable <= 1'b0;
            r_halted      <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_overflow) begin
                        r_state      <= ST_ERR;
                        r_byte_ready <= 1'b0;
                        r_load_err   <= 1'b1;
                    end else if (w_accept && byte_last) begin
                        r_state      <= ST_FLUSH;
                        r_byte_ready <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_ok) begin
                        r_state       <= ST_RUN;
                        r_core_rst    <= 1'b0;
                        r_core_enable <= 1'b1;
                    end else begin
                        r_state    <= ST_ERR;
                        r_load_err <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (instr_if_id[6:0] == HALT_OPCODE) begin
                        r_state       <= ST_HALT;
                        r_core_enable <= 1'b0;
                        r_halted      <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_ready  = r_byte_ready;
    assign imem_we     = w_we;
    assign imem_addr   = r_word_count[ADDR_W-1:0];
    assign imem_wdata  = w_wdata;
    assign core_rst    = r_core_rst;
    assign core_enable = r_core_enable;
    assign word_count  = r_word_count;
    assign halted      = r_halted;
    assign load_err    = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (ADDR_W=2): byte-queue reference model checked every cycle,
// directed literal cases, then randomized loads, halts, stray starts and resets.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned AW   = 2;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic [31:0] instr_if_id = 32'h0000_0013;
    logic        byte_ready;
    logic        imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        core_enable;
    logic [AW:0] word_count;
    logic        halted;
    logic        load_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] chk_expected = 32'h0;
    logic [31:0] chk_sum;
`endif

    imem_loader #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .instr_if_id (instr_if_id),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .chk_expected(chk_expected),
        .chk_sum     (chk_sum),
`endif
        .core_rst    (core_rst),
        .core_enable (core_enable),
        .word_count  (word_count),
        .halted      (halted),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes gather in a queue, every 4th (or last) closes a word written next cycle.
    typedef enum int {M_IDLE, M_LOAD, M_FLUSH, M_RUN, M_HALT, M_ERR} mmode_t;
    mmode_t      m_mode = M_IDLE;
    logic [7:0]  m_bytes[$];
    int          m_count = 0;
    logic [31:0] m_chk = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_err = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_word = 32'h0;
    int          m_pend_addr = 0;
    bit          chk_on = 1'b0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic model_step();
        bit          nxt_pend = 1'b0;
        logic [31:0] nxt_word = 32'h0;
        int          nxt_addr = 0;
        logic [31:0] w = 32'h0;
        if (rst) begin
            m_mode = M_IDLE;
            m_bytes.delete();
            m_count = 0;
            m_chk = 32'h0;
            m_halted = 1'b0;
            m_err = 1'b0;
        end else begin
            if (m_pend) begin
                m_count++;
                m_chk += m_pend_word;
            end
            if (start && (m_mode inside {M_IDLE, M_HALT, M_ERR})) begin
                m_mode = M_LOAD;
                m_count = 0;
                m_chk = 32'h0;
                m_halted = 1'b0;
                m_err = 1'b0;
                m_bytes.delete();
            end else begin
                case (m_mode)
                    M_LOAD: if (byte_valid) begin
                        if (m_count == MAXW) begin
                            m_mode = M_ERR;
                            m_err = 1'b1;
                        end else begin
                            m_bytes.push_back(byte_data);
                            if (m_bytes.size() == 4 || byte_last) begin
                                foreach (m_bytes[i]) w |= {24'h0, m_bytes[i]} << (8 * i);
                                nxt_pend = 1'b1;
                                nxt_word = w;
                                nxt_addr = m_count;
                                m_bytes.delete();
                                if (byte_last) m_mode = M_FLUSH;
                            end
                        end
                    end
                    M_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        if (m_chk != chk_expected) begin
                            m_mode = M_ERR;
                            m_err = 1'b1;
                        end else
`endif
                        m_mode = M_RUN;
                    end
                    M_RUN: if (instr_if_id[6:0] == 7'h7F) begin
                        m_mode = M_HALT;
                        m_halted = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
        m_pend = nxt_pend;
        m_pend_word = nxt_word;
        m_pend_addr = nxt_addr;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("byte_ready", 32'(byte_ready), 32'(m_mode == M_LOAD));
            chk("core_rst", 32'(core_rst), 32'(m_mode inside {M_IDLE, M_LOAD, M_FLUSH, M_ERR}));
            chk("core_enable", 32'(core_enable), 32'(m_mode == M_RUN));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("load_err", 32'(load_err), 32'(m_err));
            chk("word_count", 32'(word_count), 32'(m_count));
            chk("imem_we", 32'(imem_we), 32'(m_pend));
            if (m_pend) begin
                chk("imem_addr", 32'(imem_addr), 32'(m_pend_addr));
                chk("imem_wdata", imem_wdata, m_pend_word);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk("chk_sum", chk_sum, m_chk);
`endif
        end
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    logic [7:0] tx_q[$];
    bit         tx_last_en = 1'b1;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_tx(input int gap_pct);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < tx_q.size()) begin
            if (byte_ready !== 1'b1) break;
            guard++;
            if (guard > 500) begin
                n_checks++;
                n_err++;
                $display("FAIL send_budget: sent %0d of %0d bytes", idx, tx_q.size());
                break;
            end
            acc = (int'($urandom_range(99)) >= gap_pct);
            byte_valid = acc;
            byte_data  = acc ? tx_q[idx] : 8'($urandom);
            byte_last  = acc && tx_last_en && (idx == tx_q.size() - 1);
            step();
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    function automatic logic [31:0] tx_sum();
        logic [31:0] s = 32'h0;
        foreach (tx_q[i]) s += {24'h0, tx_q[i]} << (8 * (i % 4));
        return s;
    endfunction

    task automatic prep_chk(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_expected = good ? tx_sum() : $urandom;
`else
        if (good) tx_last_en = tx_last_en;
`endif
    endtask

    task automatic chk_wr(input string nm, input int i, input int addr, input logic [31:0] data);
        if (i < wr_data.size()) begin
            chk({nm, "_addr"}, 32'(wr_addr[i]), 32'(addr));
            chk({nm, "_data"}, wr_data[i], data);
        end else begin
            chk({nm, "_present"}, 32'(wr_data.size()), 32'(i + 1));
        end
    endtask

    logic [6:0] opcs[5];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        opcs = '{OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_LOAD, OPC_BRANCH};

        // Reset state and two-word load
        do_reset();
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_enable", 32'(core_enable), 32'd0);
        wr_addr.delete(); wr_data.delete();
        do_start();
        tx_q = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        tx_last_en = 1'b1;
        prep_chk(1'b1);
        send_tx(0);
        chk("t1_flush_enable", 32'(core_enable), 32'd0);
        step();
        chk("t1_run_enable", 32'(core_enable), 32'd1);
        chk("t1_count", 32'(word_count), 32'd2);
        chk_wr("t1_w0", 0, 0, 32'h0010_0013);
        chk_wr("t1_w1", 1, 1, 32'h0020_0093);

        // Halt in RUN, then restart
        instr_if_id = 32'h0000_007F;
        step();
        instr_if_id = 32'h0000_0013;
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_enable", 32'(core_enable), 32'd0);
        chk("t4_core_rst", 32'(core_rst), 32'd0);
        do_start();
        chk("t4_restart_halted", 32'(halted), 32'd0);
        chk("t4_restart_ready", 32'(byte_ready), 32'd1);

        // Zero padding of a short final word
        wr_addr.delete(); wr_data.delete();
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        prep_chk(1'b1);
        send_tx(0);
        step();
        chk_wr("t2_w0", 0, 0, 32'hDDCC_BBAA);
        chk_wr("t2_w1", 1, 1, 32'h0000_00EE);

        // Overflow: 17 bytes into a 4-word memory
        do_reset();
        wr_addr.delete(); wr_data.delete();
        do_start();
        tx_q.delete();
        for (int i = 0; i < 17; i++) tx_q.push_back(8'(i + 1));
        tx_last_en = 1'b0;
        send_tx(0);
        chk("t3_load_err", 32'(load_err), 32'd1);
        chk("t3_core_rst", 32'(core_rst), 32'd1);
        repeat (3) step();
        chk("t3_nwrites", 32'(wr_data.size()), 32'd4);
        chk_wr("t3_w3", 3, 3, 32'h100F_0E0D);

        // Last byte completing the final word is legal
        do_start();
        tx_q.delete();
        for (int i = 0; i < 16; i++) tx_q.push_back(8'(i + 1));
        tx_last_en = 1'b1;
        prep_chk(1'b1);
        send_tx(0);
        step();
        chk("full_enable", 32'(core_enable), 32'd1);
        chk("full_err", 32'(load_err), 32'd0);
        chk("full_count", 32'(word_count), 32'd4);

        // Reset mid-load, then reload with correct lane alignment
        do_reset();
        wr_addr.delete(); wr_data.delete();
        do_start();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        tx_last_en = 1'b0;
        send_tx(0);
        do_reset();
        chk("t5_count", 32'(word_count), 32'd0);
        chk("t5_core_rst", 32'(core_rst), 32'd1);
        chk("t5_nwrites", 32'(wr_data.size()), 32'd1);
        wr_addr.delete(); wr_data.delete();
        do_start();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tx_last_en = 1'b1;
        prep_chk(1'b1);
        send_tx(0);
        step();
        chk_wr("t5_w0", 0, 0, 32'h0403_0201);
        chk_wr("t5_w1", 1, 1, 32'h0807_0605);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        do_start();
        tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        chk_expected = 32'd3;
        send_tx(0);
        step();
        chk("t6_good_enable", 32'(core_enable), 32'd1);
        chk("t6_good_sum", chk_sum, 32'd3);
        do_reset();
        do_start();
        chk_expected = 32'd4;
        send_tx(0);
        step();
        chk("t6_bad_err", 32'(load_err), 32'd1);
        chk("t6_bad_enable", 32'(core_enable), 32'd0);
`endif

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(4) == 0) do_reset();
            do_start();
            n = int'($urandom_range(18, 1));
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            tx_last_en = ($urandom_range(7) != 0);
            prep_chk($urandom_range(3) != 0);
            send_tx(int'($urandom_range(40)));
            k = int'($urandom_range(12, 1));
            for (int c = 0; c < k; c++) begin
                instr_if_id = $urandom;
                instr_if_id[6:0] = ($urandom_range(99) < 15) ? 7'h7F : opcs[$urandom_range(4)];
                byte_valid = ($urandom_range(3) == 0);
                byte_data  = 8'($urandom);
                byte_last  = ($urandom_range(3) == 0);
                start      = ($urandom_range(9) == 0);
                rst        = ($urandom_range(29) == 0);
                step();
            end
            start = 1'b0;
            rst = 1'b0;
            byte_valid = 1'b0;
            byte_last = 1'b0;
            instr_if_id = 32'h0000_0013;
        end

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
